// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writeback
// sources; writes to the all-ones address are steered to a separate PC-load output.
module regfile_write_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 32
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           hold,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*ADDR_BITS-1:0]   req_address,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           rf_write_enable,
    output logic [ADDR_BITS-1:0]           rf_address,
    output logic [DATA_BITS-1:0]           rf_write_data,
    output logic                           pc_write_enable,
    output logic [DATA_BITS-1:0]           pc_write_data,
    output logic [NUM_REQ-1:0]             last_grant
);

    localparam int                   PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_BITS-1:0] PC_ADDR  = '1;
    localparam logic [PTR_W-1:0]     LAST_IDX = PTR_W'(NUM_REQ - 1);

    // Handshake: requester i transfers at a rising edge where req_valid[i] and
    // req_ready[i] are both 1; ready is a pure function of valid, hold and ptr_q.
    logic [PTR_W-1:0]     ptr_q;
    logic [PTR_W-1:0]     ptr_d;
    logic [PTR_W-1:0]     grant_idx;
    logic                 grant_found;
    logic [NUM_REQ-1:0]   grant_onehot;
    logic                 accept;
    logic [ADDR_BITS-1:0] sel_address;
    logic [DATA_BITS-1:0] sel_data;

    // Search starts at the pointer and wraps; the first valid requester wins.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            int               cand;
            logic [PTR_W-1:0] cand_idx;
            cand = int'(ptr_q) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = PTR_W'(cand);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        if (grant_found && !hold) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

    assign req_ready   = grant_onehot;
    assign accept      = grant_found & ~hold;
    assign sel_address = req_address[int'(grant_idx)*ADDR_BITS +: ADDR_BITS];
    assign sel_data    = req_data[int'(grant_idx)*DATA_BITS +: DATA_BITS];
    assign ptr_d       = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

    // Strobes are single-cycle; address/data registers only move on a matching accept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q           <= '0;
            last_grant      <= '0;
            rf_write_enable <= 1'b0;
            rf_address      <= '0;
            rf_write_data   <= '0;
            pc_write_enable <= 1'b0;
            pc_write_data   <= '0;
        end else begin
            rf_write_enable <= 1'b0;
            pc_write_enable <= 1'b0;
            if (accept) begin
                ptr_q      <= ptr_d;
                last_grant <= grant_onehot;
                if (sel_address == PC_ADDR) begin
                    pc_write_enable <= 1'b1;
                    pc_write_data   <= sel_data;
                end else begin
                    rf_write_enable <= 1'b1;
                    rf_address      <= sel_address;
                    rf_write_data   <= sel_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: one table row per clock cycle, plus
// hand-written async-reset sequences.
module tb_regfile_write_arbiter;

    logic        clock;
    logic        reset;
    logic        hold;
    logic [1:0]  req_valid;
    logic [7:0]  req_address;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic        rf_write_enable;
    logic [3:0]  rf_address;
    logic [31:0] rf_write_data;
    logic        pc_write_enable;
    logic [31:0] pc_write_data;
    logic [1:0]  last_grant;

    int vec_count;
    int fail_count;

    regfile_write_arbiter #(
        .NUM_REQ(2), .ADDR_BITS(4), .DATA_BITS(32)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .hold            (hold),
        .req_valid       (req_valid),
        .req_address     (req_address),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .rf_write_enable (rf_write_enable),
        .rf_address      (rf_address),
        .rf_write_data   (rf_write_data),
        .pc_write_enable (pc_write_enable),
        .pc_write_data   (pc_write_data),
        .last_grant      (last_grant)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        hold;
        logic [1:0]  valid;
        logic [3:0]  a0;
        logic [3:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  rdy;
        logic        rf_we;
        logic [3:0]  rf_a;
        logic [31:0] rf_d;
        logic        pc_we;
        logic [31:0] pc_d;
        logic [1:0]  lg;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            fail_count++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic h, input logic [1:0] v, input logic [3:0] a0, input logic [3:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] rdy,
                       input logic rf_we, input logic [3:0] rf_a, input logic [31:0] rf_d,
                       input logic pc_we, input logic [31:0] pc_d, input logic [1:0] lg);
        vec_t v_rec;
        v_rec.hold = h;   v_rec.valid = v;  v_rec.a0 = a0;     v_rec.a1 = a1;
        v_rec.d0 = d0;    v_rec.d1 = d1;    v_rec.rdy = rdy;   v_rec.rf_we = rf_we;
        v_rec.rf_a = rf_a; v_rec.rf_d = rf_d; v_rec.pc_we = pc_we; v_rec.pc_d = pc_d;
        v_rec.lg = lg;
        vecs.push_back(v_rec);
    endtask

    // Called just after a rising edge: drive, check ready, clock, check registered outputs.
    task automatic apply_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        hold        = v.hold;
        req_valid   = v.valid;
        req_address = {v.a1, v.a0};
        req_data    = {v.d1, v.d0};
        #1;
        check({tag, ".req_ready"}, 32'(req_ready), 32'(v.rdy));
        @(posedge clock);
        #1;
        check({tag, ".rf_we"},   32'(rf_write_enable), 32'(v.rf_we));
        check({tag, ".rf_addr"}, 32'(rf_address),      32'(v.rf_a));
        check({tag, ".rf_data"}, rf_write_data,        v.rf_d);
        check({tag, ".pc_we"},   32'(pc_write_enable), 32'(v.pc_we));
        check({tag, ".pc_data"}, pc_write_data,        v.pc_d);
        check({tag, ".lg"},      32'(last_grant),      32'(v.lg));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rf_we"},   32'(rf_write_enable), 32'h0);
        check({tag, ".rf_addr"}, 32'(rf_address),      32'h0);
        check({tag, ".rf_data"}, rf_write_data,        32'h0);
        check({tag, ".pc_we"},   32'(pc_write_enable), 32'h0);
        check({tag, ".pc_data"}, pc_write_data,        32'h0);
        check({tag, ".lg"},      32'(last_grant),      32'h0);
    endtask

    initial begin
        vec_count   = 0;
        fail_count  = 0;
        reset       = 1'b0;
        hold        = 1'b0;
        req_valid   = 2'b00;
        req_address = '0;
        req_data    = '0;

        //   hold v     a0     a1     d0            d1            rdy   rfwe rfa    rfd           pcwe pcd           lg
        add(0, 2'b01, 4'h3, 4'h0, 32'hDEADBEEF, 32'h0,        2'b01, 1, 4'h3, 32'hDEADBEEF, 0, 32'h0,        2'b01);
        add(0, 2'b00, 4'h0, 4'h0, 32'h0,        32'h0,        2'b00, 0, 4'h3, 32'hDEADBEEF, 0, 32'h0,        2'b01);
        add(0, 2'b10, 4'h0, 4'h5, 32'h0,        32'h55,       2'b10, 1, 4'h5, 32'h55,       0, 32'h0,        2'b10);
        // Contention from ptr=0: grants alternate
        add(0, 2'b11, 4'h1, 4'h2, 32'h11,       32'h22,       2'b01, 1, 4'h1, 32'h11,       0, 32'h0,        2'b01);
        add(0, 2'b11, 4'h1, 4'h2, 32'h11,       32'h22,       2'b10, 1, 4'h2, 32'h22,       0, 32'h0,        2'b10);
        add(0, 2'b11, 4'h1, 4'h2, 32'h11,       32'h22,       2'b01, 1, 4'h1, 32'h11,       0, 32'h0,        2'b01);
        add(0, 2'b11, 4'h1, 4'h2, 32'h11,       32'h22,       2'b10, 1, 4'h2, 32'h22,       0, 32'h0,        2'b10);
        // PC steering: rf address/data keep their last values
        add(0, 2'b10, 4'h0, 4'hF, 32'h0,        32'h100,      2'b10, 0, 4'h2, 32'h22,       1, 32'h100,      2'b10);
        add(0, 2'b00, 4'h0, 4'h0, 32'h0,        32'h0,        2'b00, 0, 4'h2, 32'h22,       0, 32'h100,      2'b10);
        // Hold for three cycles, then pointer-order winner (req0)
        add(1, 2'b11, 4'h6, 4'h7, 32'h66,       32'h77,       2'b00, 0, 4'h2, 32'h22,       0, 32'h100,      2'b10);
        add(1, 2'b11, 4'h6, 4'h7, 32'h66,       32'h77,       2'b00, 0, 4'h2, 32'h22,       0, 32'h100,      2'b10);
        add(1, 2'b11, 4'h6, 4'h7, 32'h66,       32'h77,       2'b00, 0, 4'h2, 32'h22,       0, 32'h100,      2'b10);
        add(0, 2'b11, 4'h6, 4'h7, 32'h66,       32'h77,       2'b01, 1, 4'h6, 32'h66,       0, 32'h100,      2'b01);
        // ptr=1, req1 idle: search wraps to req0, which writes the PC
        add(0, 2'b01, 4'hF, 4'h0, 32'h200,      32'h0,        2'b01, 0, 4'h6, 32'h66,       1, 32'h200,      2'b01);
        // Same address from both: serialised, req1 first (ptr=1), then req0
        add(0, 2'b11, 4'h9, 4'h9, 32'hAA,       32'hBB,       2'b10, 1, 4'h9, 32'hBB,       0, 32'h200,      2'b10);
        add(0, 2'b11, 4'h9, 4'h9, 32'hAA,       32'hBB,       2'b01, 1, 4'h9, 32'hAA,       0, 32'h200,      2'b01);
        add(0, 2'b00, 4'h0, 4'h0, 32'h0,        32'h0,        2'b00, 0, 4'h9, 32'hAA,       0, 32'h200,      2'b01);

        // Async reset between edges takes effect before the next edge
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("rst0");
        check("rst0.req_ready", 32'(req_ready), 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        foreach (vecs[i]) begin
            apply_vec(i, vecs[i]);
        end

        // Reset mid-transfer: ptr=1 here, only req0 valid
        hold        = 1'b0;
        req_valid   = 2'b01;
        req_address = {4'h0, 4'h4};
        req_data    = {32'h0, 32'h44};
        #1;
        check("mid.req_ready", 32'(req_ready), 32'h1);
        @(posedge clock);
        #1;
        check("mid.rf_we", 32'(rf_write_enable), 32'h1);
        check("mid.rf_addr", 32'(rf_address), 32'h4);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("mid_rst");
        #1;
        reset       = 1'b0;
        req_valid   = 2'b11;
        req_address = {4'h2, 4'h1};
        req_data    = {32'h22, 32'h11};
        #1;
        check("post_rst.req_ready", 32'(req_ready), 32'h1);
        @(posedge clock);
        #1;
        check("post_rst.rf_we", 32'(rf_write_enable), 32'h1);
        check("post_rst.rf_addr", 32'(rf_address), 32'h1);
        check("post_rst.rf_data", rf_write_data, 32'h11);
        check("post_rst.lg", 32'(last_grant), 32'h1);
        check("post_rst.req_ready2", 32'(req_ready), 32'h2);
        req_valid = 2'b00;
        @(posedge clock);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
        $finish;
    end

endmodule
